// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//
// Oversampled UART receiver feeding a first-word-fall-through receive FIFO.
// The receiver samples each bit at mid-bit. It rejects start-bit glitches,
// checks the stop bit(s), and reports framing and overrun errors through
// sticky flags. Parity checking is available as an option.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one parity bit follows the data bits. A parity mismatch sets
//               parity_err and the word is discarded. PARITY_ODD selects
//               even (0) or odd (1) parity.
//   undefined : no parity bit is expected. parity_err is tied to 0.
//
// Ports
//   clk        system clock
//   Rst        asynchronous active-high reset
//   baud_tick  one-clk enable pulse at OVERSAMPLE x baud
//   rx         asynchronous serial input, idle high
//   rd_en      pop the FIFO head (ignored while empty)
//   rd_data    FIFO head, valid while !empty (reads 0 while empty)
//   empty      FIFO empty
//   full       FIFO full
//   count      number of entries held
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a frame completed while the FIFO was full
//   parity_err sticky: parity mismatch (0 without the parity macro)
//   clr_err    clear all sticky flags (a same-cycle set takes priority)
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          Rst,
    input  logic                          baud_tick,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    input  logic                          clr_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PAR_INV  = (PARITY_ODD != 0);
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // ------------------------------------------------------------------
    // rx synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push;
    logic                 set_ferr;
    logic                 set_perr;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        push     = 1'b0;
        set_ferr = 1'b0;
        set_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit after the falling edge;
                    // a line that is high again was a glitch.
                    if (tick_q == TICK_HALF) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        // LSB arrives first: shifting in from the top leaves
                        // bit 0 in position 0 after DATA_BITS samples.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                            stop_d = 1'b0;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        par_bad_d = rx_s_q ^ (^shift_q) ^ PAR_INV;
                        set_perr  = par_bad_d;
                        state_d   = S_STOP;
                        stop_d    = 1'b0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            set_ferr = 1'b1;
                            state_d  = S_BREAK;
                        end else if (stop_q == STOP_LAST) begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            push = !par_bad_q;
`else
                            push = 1'b1;
`endif
                        end else begin
                            stop_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 do_pop;
    logic                 do_push;
    logic                 ovr_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Masking with empty gives a defined 0 out of reset without resetting mem.
    assign rd_data = empty ? '0 : mem[rd_ptr_q];
    assign count   = count_q;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic frame_err_q;
    logic overrun_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (set_ferr)     frame_err_q <= 1'b1;
            else if (clr_err) frame_err_q <= 1'b0;
            if (ovr_set)      overrun_q   <= 1'b1;
            else if (clr_err) overrun_q   <= 1'b0;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            parity_err_q <= 1'b0;
        end else if (set_perr) begin
            parity_err_q <= 1'b1;
        end else if (clr_err) begin
            parity_err_q <= 1'b0;
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_par;
    assign unused_par = (PARITY_ODD != 0) ^ set_perr;
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Drives serial frames into uart_rx_fifo (8 data bits, 16x oversample,
// 1 stop bit, 4-entry FIFO). Every frame also updates a queue-based model of
// the receive path. After each step the DUT status and head word are compared
// against that model. The bench runs directed cases first, then randomized
// frames with random reads and random flag clears.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          Rst;
    logic          baud_tick;
    logic          rx;
    logic          rd_en;
    logic [DB-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [2:0]    count;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;
    logic          clr_err;

    uart_rx_fifo #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .STOP_BITS (1),
        .FIFO_DEPTH(DEPTH),
        .PARITY_ODD(int'(PAR_ODD))
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: received words in order, plus the sticky flags.
    logic [DB-1:0] mq[$];
    bit m_ferr = 1'b0;
    bit m_ovr  = 1'b0;
    bit m_perr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [31:0] head;
        head = (mq.size() > 0) ? 32'(mq[0]) : 32'd0;
        check_eq({tag, ".count"},      32'(count),      32'(mq.size()));
        check_eq({tag, ".empty"},      32'(empty),      32'(mq.size() == 0));
        check_eq({tag, ".full"},       32'(full),       32'(mq.size() == DEPTH));
        check_eq({tag, ".rd_data"},    32'(rd_data),    head);
        check_eq({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
        check_eq({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        check_eq({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
        $display("[TB] %s: count=%0d head=0x%0h ferr=%0d ovr=%0d perr=%0d",
                 tag, count, rd_data, frame_err, overrun, parity_err);
    endtask

    // One baud tick, preceded by three quiet clocks so the synchroniser
    // has settled on the current rx level.
    task automatic tick_once(input bit with_pop);
        repeat (3) @(negedge clk);
        baud_tick = 1'b1;
        rd_en     = with_pop;
        @(negedge clk);
        baud_tick = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) tick_once(1'b0);
    endtask

    // Send one frame. pop_at_stop raises rd_en in the clock of the stop-bit
    // mid-point tick, so the pop coincides with the push.
    task automatic send_frame(input logic [DB-1:0] d, input bit stop_val,
                              input bit par_flip, input bit pop_at_stop);
        int nb;
        logic b;
        int was;
        bit popped;
        bit par_bad;
        logic [DB-1:0] junk;
        nb = DB + 2 + (PAR_EN ? 1 : 0);
        for (int k = 0; k < nb; k++) begin
            if (k == 0)                      b = 1'b0;
            else if (k <= DB)                b = d[k-1];
            else if (PAR_EN && k == DB + 1)  b = (^d) ^ PAR_ODD ^ par_flip;
            else                             b = stop_val;
            rx = b;
            for (int j = 0; j < OS; j++)
                tick_once(pop_at_stop && (k == nb - 1) && (j == OS / 2));
        end
        par_bad = PAR_EN && par_flip;
        was     = mq.size();
        popped  = 1'b0;
        if (pop_at_stop && was > 0) begin
            junk   = mq.pop_front();
            popped = 1'b1;
        end
        if (!stop_val) m_ferr = 1'b1;
        if (par_bad)   m_perr = 1'b1;
        if (stop_val && !par_bad) begin
            if (was < DEPTH || popped) mq.push_back(d);
            else                       m_ovr = 1'b1;
        end
        $display("[TB] frame 0x%02h stop=%0d par_flip=%0d pop_at_stop=%0d -> model count %0d",
                 d, stop_val, par_flip, pop_at_stop, mq.size());
    endtask

    task automatic pop_word(input string tag);
        logic [DB-1:0] exp;
        @(negedge clk);
        if (mq.size() > 0) begin
            exp = mq.pop_front();
            check_eq({tag, ".pop"}, 32'(rd_data), 32'(exp));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
    endtask

    initial begin
        logic [DB-1:0] rnd;
        Rst = 1'b1; baud_tick = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");

        // Single clean frame, then read it out.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_state("a5_rx");
        pop_word("a5");
        check_state("a5_pop");

        // Short low pulse on rx: start bit rejected.
        rx = 1'b0;
        for (int i = 0; i < 4; i++) tick_once(1'b0);
        idle(20);
        check_state("glitch");

        // Framing error, long break, then recovery.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_state("ferr");
        rx = 1'b0;
        for (int i = 0; i < 20 * OS; i++) tick_once(1'b0);
        idle(OS);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_state("after_break");
        clear_flags();
        check_state("clr_ferr");
        pop_word("x81");

        // Overflow: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(DB'(i), 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        check_state("overflow");
        for (int i = 0; i < 4; i++) pop_word("ovf_rd");
        clear_flags();
        check_state("ovf_drained");

        // Full FIFO with a pop in the same cycle as the push.
        for (int i = 0; i < 4; i++) begin
            send_frame(DB'(8'h11 + i), 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        idle(2);
        check_state("push_pop_full");
        for (int i = 0; i < 4; i++) pop_word("pp_rd");
        check_state("pp_drained");

        // Reset during a data bit.
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        idle(2);
        rx = 1'b0;
        for (int i = 0; i < OS * 3 + 5; i++) tick_once(1'b0);
        #2 Rst = 1'b1;
        #2 Rst = 1'b0;
        rx = 1'b1;
        mq.delete();
        m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        check_state("rst_mid");
        idle(4);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_state("after_rst");
        pop_word("x5a");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_state("par_ok");
        pop_word("par_ok");
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(2);
        check_state("par_bad");
        clear_flags();
`endif

        // Randomized frames, reads and flag clears.
        for (int it = 0; it < 30; it++) begin
            int npop;
            rnd = DB'($urandom_range(0, 255));
            send_frame(rnd, $urandom_range(0, 9) != 0,
                       PAR_EN && ($urandom_range(0, 7) == 0),
                       $urandom_range(0, 3) == 0);
            idle(2);
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) pop_word("rnd");
            if ($urandom_range(0, 9) == 0) clear_flags();
            check_state("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
